// File: rtl/shift_add_mult_pkg.sv
// ============================================================================
// Module  : shift_add_mult_pkg
// Purpose : Shared types and helpers for the sequential shift-add multiplier.
//           - mult_state_t : controller state (IDLE, RUN)
//           - cnt_w(d)     : width of a counter able to hold 0..d
// Config  : none here; SHIFT_ADD_MULT_SIGNED_EN is consumed by the RTL files.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_mult_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_step.sv
// ============================================================================
// Module  : shift_add_step
// Purpose : Combinational single partial-product step of the shift-add
//           multiplier: conditional add/subtract of the multiplicand into the
//           accumulator followed by a one-bit right shift of {acc, mq}.
// Ports   : acc      [D_SIZE:0]   current accumulator
//           mq       [D_SIZE-1:0] current multiplier shift register
//           mcand    [D_SIZE-1:0] captured multiplicand
//           sgn                   two's-complement mode for this operation
//           last                  this is the final step (count = D_SIZE-1)
//           acc_next [D_SIZE:0]   accumulator after the step
//           mq_next  [D_SIZE-1:0] multiplier register after the step
// Config  : SHIFT_ADD_MULT_SIGNED_EN - when undefined the subtract path for
//           the signed final step is not built.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_step #(
  parameter int D_SIZE = 8
) (
  input  logic [D_SIZE:0]   acc,
  input  logic [D_SIZE-1:0] mq,
  input  logic [D_SIZE-1:0] mcand,
  input  logic              sgn,
  input  logic              last,
  output logic [D_SIZE:0]   acc_next,
  output logic [D_SIZE-1:0] mq_next
);

  logic [D_SIZE:0]   ext;
  // One extra bit above the accumulator catches the unsigned carry out.
  logic [D_SIZE+1:0] sum;
  logic              msb_in;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic do_sub;
  // The multiplier's MSB has negative weight in two's complement, so the
  // last partial product is subtracted instead of added.
  assign do_sub = sgn & last;
`else
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    ext = {sgn & mcand[D_SIZE-1], mcand};
    sum = {1'b0, acc};
    if (mq[0]) begin
`ifdef SHIFT_ADD_MULT_SIGNED_EN
      if (do_sub) begin
        sum = {1'b0, acc} - {1'b0, ext};
      end else begin
        sum = {1'b0, acc} + {1'b0, ext};
      end
`else
      sum = {1'b0, acc} + {1'b0, ext};
`endif
    end
    // Signed: the D_SIZE+1-bit result cannot overflow, so its MSB is the
    // true sign to replicate. Unsigned: the carry is the bit shifted in.
    msb_in   = sgn ? sum[D_SIZE] : sum[D_SIZE+1];
    acc_next = {msb_in, sum[D_SIZE:1]};
    mq_next  = {sum[0], mq[D_SIZE-1:1]};
  end

endmodule

`default_nettype wire

// File: rtl/shift_add_mult.sv
// ============================================================================
// Module  : shift_add_mult
// Purpose : Parametrised sequential shift-add multiplier, one partial
//           product per clock, with start/busy/done handshake.
// Ports   : clk_in                       clock, rising edge
//           rst_in                       asynchronous active-high reset
//           strt_in                      start request (ignored while busy)
//           signed_in                    two's-complement operands
//           a_in        [D_SIZE-1:0]     multiplicand
//           b_in        [D_SIZE-1:0]     multiplier
//           busy_out                     operation in progress
//           done_out                     one-cycle pulse on product update
//           product_out [2*D_SIZE-1:0]   result, held until next completion
// Config  : SHIFT_ADD_MULT_SIGNED_EN - define to honour signed_in; when
//           undefined all operations are unsigned and signed_in is ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int D_SIZE = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  strt_in,
  input  logic                  signed_in,
  input  logic [D_SIZE-1:0]     a_in,
  input  logic [D_SIZE-1:0]     b_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [2*D_SIZE-1:0]   product_out
);

  localparam int            CW       = cnt_w(D_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(D_SIZE - 1);

  mult_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [D_SIZE:0]       acc_q, acc_d;
  logic [D_SIZE-1:0]     mq_q, mq_d;
  logic [D_SIZE-1:0]     mcand_q, mcand_d;
  logic                  sgn_q, sgn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2*D_SIZE-1:0]   product_q, product_d;

  logic                  sgn_start;
  logic                  last_step;
  logic [D_SIZE:0]       acc_step;
  logic [D_SIZE-1:0]     mq_step;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  assign sgn_start = signed_in;
`else
  logic unused_signed_in;
  assign unused_signed_in = signed_in;
  assign sgn_start        = 1'b0;
`endif

  assign last_step = (cnt_q == LAST_CNT);

  shift_add_step #(
    .D_SIZE (D_SIZE)
  ) u_step (
    .acc      (acc_q),
    .mq       (mq_q),
    .mcand    (mcand_q),
    .sgn      (sgn_q),
    .last     (last_step),
    .acc_next (acc_step),
    .mq_next  (mq_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    sgn_d     = sgn_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (strt_in) begin
          mcand_d = a_in;
          mq_d    = b_in;
          acc_d   = '0;
          sgn_d   = sgn_start;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // strt_in is deliberately not looked at here: no queuing.
        acc_d = acc_step;
        mq_d  = mq_step;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          product_d = {acc_step[D_SIZE-1:0], mq_step};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      sgn_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      sgn_q     <= sgn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign product_out = product_q;

endmodule

`default_nettype wire
